// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: fills a run of consecutive bank registers with a generalised
// Fibonacci sequence, one term per clock, using read ports 1/2 and the write port.
// Optional build macro: FIB_SEQ_SATURATE_EN (saturate terms on carry-out
// instead of wrapping).
module fib_seq_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_terms,
  input  logic [ADDR_W-1:0] base_dir,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_dir,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_read_dir1,
  output logic [ADDR_W-1:0] rf_read_dir2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_W0   = 3'd1;
  localparam logic [2:0] S_W1   = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_n;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_i;
  logic [DATA_W-1:0] r_seed0;
  logic [DATA_W-1:0] r_seed1;
  logic              r_ovf;

  logic [DATA_W:0]   w_sum;
  logic              w_carry;
  logic [DATA_W-1:0] w_term;
  logic [ADDR_W-1:0] w_calc_dir;
  logic              w_last;

  // Sum of the two previous terms, one bit wider to expose the carry-out
  assign w_sum   = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};
  assign w_carry = w_sum[DATA_W];

`ifdef FIB_SEQ_SATURATE_EN
  // Clamp to all-ones on carry-out; later sums with this term keep saturating
  assign w_term = w_carry ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
  // Wrap modulo 2^DATA_W; overflow flag still records the carry
  assign w_term = w_sum[DATA_W-1:0];
`endif

  // Address of term i; arithmetic wraps modulo the bank depth
  assign w_calc_dir = r_base + r_i;
  assign w_last     = (r_i == (r_n - ADDR_W'(1)));
  assign overflow   = r_ovf;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Run parameters, term index and sticky overflow
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_n     <= '0;
      r_base  <= '0;
      r_i     <= '0;
      r_seed0 <= '0;
      r_seed1 <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n     <= n_terms;
            r_base  <= base_dir;
            r_seed0 <= seed0;
            r_seed1 <= seed1;
            r_i     <= '0;
            r_ovf   <= 1'b0;
          end
        end
        S_W1:   r_i <= ADDR_W'(2);
        S_CALC: begin
          r_i <= r_i + ADDR_W'(1);
          if (w_carry) r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and bank-port decode from registered state
  always_comb begin
    w_state_nxt   = r_state;
    busy          = 1'b0;
    done          = 1'b0;
    rf_write_en   = 1'b0;
    rf_write_dir  = '0;
    rf_write_data = '0;
    rf_read_dir1  = '0;
    rf_read_dir2  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (n_terms != '0) ? S_W0 : S_DONE;
      end
      S_W0: begin
        busy          = 1'b1;
        rf_write_en   = 1'b1;
        rf_write_dir  = r_base;
        rf_write_data = r_seed0;
        w_state_nxt   = (r_n >= ADDR_W'(2)) ? S_W1 : S_DONE;
      end
      S_W1: begin
        busy          = 1'b1;
        rf_write_en   = 1'b1;
        rf_write_dir  = r_base + ADDR_W'(1);
        rf_write_data = r_seed1;
        w_state_nxt   = (r_n >= ADDR_W'(3)) ? S_CALC : S_DONE;
      end
      S_CALC: begin
        busy          = 1'b1;
        rf_write_en   = 1'b1;
        rf_write_dir  = w_calc_dir;
        rf_write_data = w_term;
        rf_read_dir1  = w_calc_dir - ADDR_W'(2);
        rf_read_dir2  = w_calc_dir - ADDR_W'(1);
        w_state_nxt   = w_last ? S_DONE : S_CALC;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a behavioural 32x32 register bank.
module tb_fib_seq_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          start;
  logic [AW-1:0] n_terms;
  logic [AW-1:0] base_dir;
  logic [DW-1:0] seed0;
  logic [DW-1:0] seed1;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          rf_write_en;
  logic [AW-1:0] rf_write_dir;
  logic [DW-1:0] rf_write_data;
  logic [AW-1:0] rf_read_dir1;
  logic [AW-1:0] rf_read_dir2;
  logic [DW-1:0] rf_read_data1;
  logic [DW-1:0] rf_read_data2;

  logic [DW-1:0] bank [32];
  logic          clr;

  int total = 0;
  int bad   = 0;

  int done_idx;
  int busy_cnt;
  int we_cnt;
  logic [AW-1:0] rd1_log [41];
  logic [AW-1:0] rd2_log [41];
  logic [AW-1:0] wd_log  [41];

  always #5 clk = ~clk;

  fib_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .start         (start),
    .n_terms       (n_terms),
    .base_dir      (base_dir),
    .seed0         (seed0),
    .seed1         (seed1),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .rf_write_en   (rf_write_en),
    .rf_write_dir  (rf_write_dir),
    .rf_write_data (rf_write_data),
    .rf_read_dir1  (rf_read_dir1),
    .rf_read_dir2  (rf_read_dir2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2)
  );

  // Register bank model: combinational reads, write on rising edge
  always @(posedge clk) begin
    if (clr) begin
      for (int j = 0; j < 32; j++) bank[j] <= 32'hA5A5_0000 | 32'(j);
    end else if (rf_write_en) begin
      bank[rf_write_dir] <= rf_write_data;
    end
  end

  assign rf_read_data1 = bank[rf_read_dir1];
  assign rf_read_data2 = bank[rf_read_dir2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One run; optional mid-run start poke and mid-run reset abort (-1 = none)
  task automatic run_seq(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                         input logic [AW-1:0] b, input logic [AW-1:0] n,
                         input int poke_idx, input int abort_idx);
    bit fin;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    seed0 = s0; seed1 = s1; base_dir = b; n_terms = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_idx = -1; busy_cnt = 0; we_cnt = 0; fin = 1'b0;
    for (int k = 0; k <= 40 && !fin; k++) begin
      rd1_log[k] = rf_read_dir1;
      rd2_log[k] = rf_read_dir2;
      wd_log[k]  = rf_write_dir;
      if (busy) busy_cnt++;
      if (rf_write_en) we_cnt++;
      if (done) begin
        done_idx = k;
        fin = 1'b1;
      end
      if (k == poke_idx) begin
        start = 1'b1; base_dir = 5'd20; n_terms = 5'd2;
        seed0 = 32'h7777_7777; seed1 = 32'h8888_8888;
      end else begin
        start = 1'b0;
      end
      if (k == abort_idx) begin
        check_eq("ovf_before_rst", 32'(overflow), 32'd1);
        arst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_we", 32'(rf_write_en), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_wdir", 32'(rf_write_dir), 32'd0);
        @(posedge clk); #1;
        check_eq("rst_we_hold", 32'(rf_write_en), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; clr = 1'b0;
    n_terms = '0; base_dir = '0; seed0 = '0; seed1 = '0;
    #12;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_ovf", 32'(overflow), 32'd0);
    check_eq("reset_we", 32'(rf_write_en), 32'd0);
    check_eq("reset_wdir", 32'(rf_write_dir), 32'd0);
    check_eq("reset_wdata", rf_write_data, 32'd0);
    check_eq("reset_rdir1", 32'(rf_read_dir1), 32'd0);
    @(negedge clk); arst_n = 1'b1;

    // Classic Fibonacci, base 4, n=10, with an ignored start pulse mid-run
    run_seq(32'd0, 32'd1, 5'd4, 5'd10, 3, -1);
    check_eq("fib_done_idx", 32'(done_idx), 32'd10);
    check_eq("fib_busy_cnt", 32'(busy_cnt), 32'd11);
    check_eq("fib_we_cnt", 32'(we_cnt), 32'd10);
    check_eq("fib_ovf", 32'(overflow), 32'd0);
    check_eq("fib_r4", bank[4], 32'd0);
    check_eq("fib_r5", bank[5], 32'd1);
    check_eq("fib_r6", bank[6], 32'd1);
    check_eq("fib_r7", bank[7], 32'd2);
    check_eq("fib_r8", bank[8], 32'd3);
    check_eq("fib_r9", bank[9], 32'd5);
    check_eq("fib_r10", bank[10], 32'd8);
    check_eq("fib_r11", bank[11], 32'd13);
    check_eq("fib_r12", bank[12], 32'd21);
    check_eq("fib_r13", bank[13], 32'd34);
    check_eq("fib_r14_untouched", bank[14], 32'hA5A5_000E);
    check_eq("poke_r20_untouched", bank[20], 32'hA5A5_0014);
    @(posedge clk); #1;
    check_eq("fib_idle_busy", 32'(busy), 32'd0);
    check_eq("fib_idle_done", 32'(done), 32'd0);

    // n=0: straight to DONE, no writes
    run_seq(32'h1111_1111, 32'h2222_2222, 5'd7, 5'd0, -1, -1);
    check_eq("n0_done_idx", 32'(done_idx), 32'd0);
    check_eq("n0_we_cnt", 32'(we_cnt), 32'd0);
    check_eq("n0_busy_cnt", 32'(busy_cnt), 32'd1);
    check_eq("n0_r7", bank[7], 32'hA5A5_0007);

    // n=1: only seed0 written
    run_seq(32'h0000_1234, 32'h0000_5678, 5'd10, 5'd1, -1, -1);
    check_eq("n1_done_idx", 32'(done_idx), 32'd1);
    check_eq("n1_we_cnt", 32'(we_cnt), 32'd1);
    check_eq("n1_r10", bank[10], 32'h0000_1234);
    check_eq("n1_r11", bank[11], 32'hA5A5_000B);

    // Address wrap past register 31
    run_seq(32'd2, 32'd3, 5'd30, 5'd5, -1, -1);
    check_eq("wrap_done_idx", 32'(done_idx), 32'd5);
    check_eq("wrap_r30", bank[30], 32'd2);
    check_eq("wrap_r31", bank[31], 32'd3);
    check_eq("wrap_r0", bank[0], 32'd5);
    check_eq("wrap_r1", bank[1], 32'd8);
    check_eq("wrap_r2", bank[2], 32'd13);
    check_eq("wrap_rd1_c2", 32'(rd1_log[2]), 32'd30);
    check_eq("wrap_wd_c2", 32'(wd_log[2]), 32'd0);
    check_eq("wrap_rd1_c3", 32'(rd1_log[3]), 32'd31);
    check_eq("wrap_rd2_c3", 32'(rd2_log[3]), 32'd0);
    check_eq("wrap_wd_c3", 32'(wd_log[3]), 32'd1);

    // Carry-out on term 2
    run_seq(32'hFFFF_FFF0, 32'h0000_0020, 5'd16, 5'd4, -1, -1);
    check_eq("ovf_done_idx", 32'(done_idx), 32'd4);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_t0", bank[16], 32'hFFFF_FFF0);
    check_eq("ovf_t1", bank[17], 32'h0000_0020);
`ifdef FIB_SEQ_SATURATE_EN
    check_eq("ovf_t2", bank[18], 32'hFFFF_FFFF);
    check_eq("ovf_t3", bank[19], 32'hFFFF_FFFF);
`else
    check_eq("ovf_t2", bank[18], 32'h0000_0010);
    check_eq("ovf_t3", bank[19], 32'h0000_0030);
`endif
    @(posedge clk); #1;
    check_eq("ovf_sticky_idle", 32'(overflow), 32'd1);

    // Reset during CALC after an overflow: writes stop, flag cleared
    run_seq(32'hFFFF_FFF0, 32'h0000_0020, 5'd4, 5'd10, -1, 5);
    check_eq("abort_r6", bank[6],
`ifdef FIB_SEQ_SATURATE_EN
             32'hFFFF_FFFF);
`else
             32'h0000_0010);
`endif
    check_eq("abort_r8", bank[8],
`ifdef FIB_SEQ_SATURATE_EN
             32'hFFFF_FFFF);
`else
             32'h0000_0040);
`endif
    check_eq("abort_r9_untouched", bank[9], 32'hA5A5_0009);
    check_eq("abort_r10_untouched", bank[10], 32'hA5A5_000A);

    // Normal run after abort
    run_seq(32'd5, 32'd7, 5'd0, 5'd4, -1, -1);
    check_eq("post_done_idx", 32'(done_idx), 32'd4);
    check_eq("post_ovf", 32'(overflow), 32'd0);
    check_eq("post_r2", bank[2], 32'd12);
    check_eq("post_r3", bank[3], 32'd19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
